// File: rtl/dram_port_arbiter_if.sv
// One requester port of the DRAM arbiter: request bus in, grant/stall/read-valid back.
interface dram_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        stall;
  logic        rvalid;

  modport master (output req, we, addr, wdata, input gnt, stall, rvalid);
  modport slave  (input req, we, addr, wdata, output gnt, stall, rvalid);
endinterface

// File: rtl/dram_port_arbiter.sv
// Shares one synchronous-read DRAM between the CPU MEM stage (port C) and a
// DMA/loader engine (port D). C has fixed priority; a starvation counter hands
// D a conflicting cycle once it has been denied MAX_WAIT cycles in a row.
// Read ownership is registered so the returned word is flagged to its issuer.
module dram_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dram_port_arbiter_if.slave   c_port,
  dram_port_arbiter_if.slave   d_port,
  output logic [31:0]          rdata_o,
  output logic [31:0]          dram_a_o,
  output logic                 dram_we_o,
  output logic [31:0]          dram_din_o,
  input  logic [31:0]          dram_spo_i,
  output logic [CNT_W-1:0]     conflict_cnt_o
);

  // A zero-width counter is illegal, so MAX_WAIT = 0 keeps one bit that never moves.
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;

  logic both_req;
  logic d_wins;
  logic c_gnt;
  logic d_gnt;

  // Grant decision, DRAM steering and next-state for the counters.
  always_comb begin
    both_req   = c_port.req & d_port.req;
    d_wins     = both_req & (wait_q == WAIT_MAX);
    c_gnt      = ~rst & c_port.req & ~d_wins;
    d_gnt      = ~rst & d_port.req & (~c_port.req | d_wins);

    // With no grant the C inputs sit on the address/data bus; only we matters.
    dram_a_o   = d_gnt ? d_port.addr  : c_port.addr;
    dram_din_o = d_gnt ? d_port.wdata : c_port.wdata;
    dram_we_o  = (c_gnt & c_port.we) | (d_gnt & d_port.we);

    wait_d = wait_q;
    if (~d_port.req | d_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    rd_owner_d = {c_gnt & ~c_port.we, d_gnt & ~d_port.we};

    conflict_d = conflict_q;
    if (both_req && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_d = conflict_q + CNT_W'(1);
    end
  end

  // Port-facing outputs; D never stalls anything upstream.
  always_comb begin
    c_port.gnt     = c_gnt;
    c_port.stall   = ~rst & c_port.req & ~c_gnt;
    c_port.rvalid  = rd_owner_q[1];
    d_port.gnt     = d_gnt;
    d_port.stall   = 1'b0;
    d_port.rvalid  = rd_owner_q[0];
    rdata_o        = dram_spo_i;
    conflict_cnt_o = conflict_q;
  end

  // State registers with synchronous reset; a read granted just before reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q     <= '0;
      rd_owner_q <= '0;
      conflict_q <= '0;
    end else begin
      wait_q     <= wait_d;
      rd_owner_q <= rd_owner_d;
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench: instance A (MAX_WAIT=4, CNT_W=4) covers basic access,
// starvation and saturation; instance B (MAX_WAIT=0) covers D-always-wins.
module tb_dram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  dram_port_arbiter_if ca ();
  dram_port_arbiter_if da ();
  dram_port_arbiter_if cb ();
  dram_port_arbiter_if db ();

  logic [31:0] a_rdata, a_a, a_din, a_spo;
  logic        a_we;
  logic [3:0]  a_cnt;
  logic [31:0] b_rdata, b_a, b_din, b_spo;
  logic        b_we;
  logic [15:0] b_cnt;

  dram_port_arbiter #(.MAX_WAIT(4), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .c_port(ca), .d_port(da),
    .rdata_o(a_rdata), .dram_a_o(a_a), .dram_we_o(a_we), .dram_din_o(a_din),
    .dram_spo_i(a_spo), .conflict_cnt_o(a_cnt)
  );

  dram_port_arbiter #(.MAX_WAIT(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .c_port(cb), .d_port(db),
    .rdata_o(b_rdata), .dram_a_o(b_a), .dram_we_o(b_we), .dram_din_o(b_din),
    .dram_spo_i(b_spo), .conflict_cnt_o(b_cnt)
  );

  // Write-first synchronous-read DRAM models.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  always @(posedge clk) begin
    if (a_we) mem_a[a_a[9:2]] <= a_din;
    a_spo <= a_we ? a_din : mem_a[a_a[9:2]];
    if (b_we) mem_b[b_a[9:2]] <= b_din;
    b_spo <= b_we ? b_din : mem_b[b_a[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd);
    ca.req = creq; ca.we = cwe; ca.addr = caddr; ca.wdata = cwd;
    da.req = dreq; da.we = dwe; da.addr = daddr; da.wdata = dwd;
  endtask

  task automatic drv_b(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd);
    cb.req = creq; cb.we = cwe; cb.addr = caddr; cb.wdata = cwd;
    db.req = dreq; db.we = dwe; db.addr = daddr; db.wdata = dwd;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_c [10];
    drv_a(1'b1, 1'b1, 32'h10, 32'h0, 1'b1, 1'b1, 32'h14, 32'h0);
    drv_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    // Reset with requests active: nothing granted, nothing written.
    to_neg();
    chk("rst_cgnt",  32'(ca.gnt),   32'd0);
    chk("rst_dgnt",  32'(da.gnt),   32'd0);
    chk("rst_we",    32'(a_we),     32'd0);
    chk("rst_stall", 32'(ca.stall), 32'd0);
    to_next();
    to_neg();
    chk("rst_cnt",    32'(a_cnt),     32'd0);
    chk("rst_rvalid", 32'(ca.rvalid), 32'd0);
    to_next();
    rst = 1'b0;

    // C write then read of 0x10.
    drv_a(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("w_cgnt",  32'(ca.gnt),   32'd1);
    chk("w_we",    32'(a_we),     32'd1);
    chk("w_addr",  a_a,           32'h10);
    chk("w_din",   a_din,         32'hDEADBEEF);
    chk("w_stall", 32'(ca.stall), 32'd0);
    to_next();
    drv_a(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("r_cgnt",   32'(ca.gnt),    32'd1);
    chk("r_we",     32'(a_we),      32'd0);
    chk("w_norval", 32'(ca.rvalid), 32'd0);
    to_next();
    drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("r_crval", 32'(ca.rvalid), 32'd1);
    chk("r_drval", 32'(da.rvalid), 32'd0);
    chk("r_data",  a_rdata,        32'hDEADBEEF);
    to_next();

    // Preload 0x40 via C and 0x44 via D, then alternate reads.
    drv_a(1'b1, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0);
    to_next();
    drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h22222222);
    to_neg();
    chk("dw_dgnt",  32'(da.gnt),   32'd1);
    chk("dw_cgnt",  32'(ca.gnt),   32'd0);
    chk("dw_addr",  a_a,           32'h44);
    chk("dw_we",    32'(a_we),     32'd1);
    chk("dw_stall", 32'(ca.stall), 32'd0);
    to_next();
    drv_a(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_next();
    drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
    to_neg();
    chk("alt_crval", 32'(ca.rvalid), 32'd1);
    chk("alt_drval", 32'(da.rvalid), 32'd0);
    chk("alt_cdata", a_rdata,        32'h11111111);
    to_next();
    drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("alt_drval2", 32'(da.rvalid), 32'd1);
    chk("alt_crval2", 32'(ca.rvalid), 32'd0);
    chk("alt_ddata",  a_rdata,        32'h22222222);
    to_next();
    to_neg();
    chk("idle_crval", 32'(ca.rvalid), 32'd0);
    chk("idle_drval", 32'(da.rvalid), 32'd0);
    to_next();

    // Starvation: both read continuously; D wins on cycles 4 and 9.
    for (int i = 0; i < 10; i++) exp_c[i] = (i != 4) && (i != 9);
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drv_a(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      else        drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      to_neg();
      if (i < 10) begin
        chk($sformatf("stv_cgnt%0d", i),  32'(ca.gnt),   32'(exp_c[i]));
        chk($sformatf("stv_dgnt%0d", i),  32'(da.gnt),   32'(!exp_c[i]));
        chk($sformatf("stv_stall%0d", i), 32'(ca.stall), 32'(!exp_c[i]));
      end
      if (i > 0) begin
        chk($sformatf("stv_crv%0d", i), 32'(ca.rvalid), 32'(exp_c[i-1]));
        chk($sformatf("stv_drv%0d", i), 32'(da.rvalid), 32'(!exp_c[i-1]));
        chk($sformatf("stv_dat%0d", i), a_rdata, exp_c[i-1] ? 32'h11111111 : 32'h22222222);
      end
      if (i == 10) chk("stv_cnt", 32'(a_cnt), 32'd10);
      to_next();
    end

    // Reset right after a granted C read drops its rvalid and clears counters.
    drv_a(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_next();
    drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    to_next();
    rst = 1'b0;
    to_neg();
    chk("rr_crval", 32'(ca.rvalid), 32'd0);
    chk("rr_cnt",   32'(a_cnt),     32'd0);
    to_next();

    // Saturation: 21 conflict cycles, first one confirms wait counter was cleared.
    for (int i = 0; i < 21; i++) begin
      drv_a(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      to_neg();
      if (i == 0) chk("rr_cfirst", 32'(ca.gnt), 32'd1);
      to_next();
    end
    drv_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("sat_cnt", 32'(a_cnt), 32'h0000000F);
    to_next();

    // MAX_WAIT = 0: D wins the write conflict, C's write lands next cycle.
    drv_b(1'b1, 1'b1, 32'h20, 32'hCCCC0001, 1'b1, 1'b1, 32'h20, 32'hD00D0002);
    to_neg();
    chk("mw0_dgnt",  32'(db.gnt),   32'd1);
    chk("mw0_cgnt",  32'(cb.gnt),   32'd0);
    chk("mw0_stall", 32'(cb.stall), 32'd1);
    chk("mw0_din",   b_din,         32'hD00D0002);
    chk("mw0_we",    32'(b_we),     32'd1);
    to_next();
    drv_b(1'b1, 1'b1, 32'h20, 32'hCCCC0001, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("mw0_cgnt2",  32'(cb.gnt),   32'd1);
    chk("mw0_din2",   b_din,         32'hCCCC0001);
    chk("mw0_stall2", 32'(cb.stall), 32'd0);
    to_next();
    drv_b(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_next();
    drv_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    to_neg();
    chk("mw0_crval", 32'(cb.rvalid), 32'd1);
    chk("mw0_data",  b_rdata,        32'hCCCC0001);
    chk("mw0_cnt",   32'(b_cnt),     32'd1);
    to_next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
